// File: rtl/updown_pulse_tx_pkg.sv
// Shared types and defaults for the up/down step-pulse transmitter.
// Holds the FSM state encoding, the pulse-select encoding and the
// default pulse timing used by the transmitter and its phase timer.
package updown_pulse_tx_pkg;

  // Transmitter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  // Which pulse line is active during HIGH.
  // The encoding doubles as the bit index into the one-hot pulse vector.
  typedef enum logic [1:0] {
    SEL_UP  = 2'd0,
    SEL_DN  = 2'd1,
    SEL_CLR = 2'd2
  } sel_e;

  // Number of distinct pulse lines (UP, DN, CLR).
  localparam int NUM_PULSE = 3;

  // Default pulse timing. The receiver uses a 2-FF edge detector, so
  // neither phase may be shorter than 2 cycles.
  localparam int DEF_HIGH_CYC = 2;
  localparam int DEF_LOW_CYC  = 2;

  // Larger of two integers; sizes the shared phase counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/updown_pulse_tx_if.sv
// Host-side bundle of the up/down step-pulse transmitter.
// The master side (host) drives the target/strobes and observes the
// pulse lines and status; the slave side is the transmitter itself.
interface updown_pulse_tx_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] TARGET;
  logic             LOAD;
  logic             CLR_REQ;
  logic             UP_OUT;
  logic             DN_OUT;
  logic             CLR_OUT;
  logic [WIDTH-1:0] POS;
  logic             BUSY;
  logic             DONE;

  modport master (
    output TARGET, LOAD, CLR_REQ,
    input  UP_OUT, DN_OUT, CLR_OUT, POS, BUSY, DONE
  );

  modport slave (
    input  TARGET, LOAD, CLR_REQ,
    output UP_OUT, DN_OUT, CLR_OUT, POS, BUSY, DONE
  );

endinterface

// File: rtl/updown_pulse_tx_phase_timer.sv
// Loadable down-counter that times one pulse phase (HIGH or LOW).
// A start strobe loads the phase length; expire is high during the
// last cycle of the phase so the owner can switch phase on that edge.
// A start arriving in the expiry cycle re-arms it back-to-back.
module updown_pulse_tx_phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_reg;
  logic             active_reg;

  // Count the phase down; start always wins so phases can chain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_reg    <= '0;
      active_reg <= 1'b0;
    end else if (start) begin
      cnt_reg    <= load_val - CNT_W'(1);
      active_reg <= 1'b1;
    end else if (active_reg) begin
      if (cnt_reg == '0) begin
        active_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
    end
  end

  assign expire = active_reg && (cnt_reg == '0);

endmodule

// File: rtl/updown_pulse_tx.sv
// Up/down step-pulse transmitter.
// Drives UP/DN/CLR pulses to a remote edge-counting counter until the
// locally mirrored count (POS) equals the requested target (TGT),
// always stepping the short way around the WIDTH-bit wrap. A requested
// clear is deferred until the pulse in flight has finished its HIGH and
// LOW phases, then takes priority over any stepping.
module updown_pulse_tx
  import updown_pulse_tx_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int HIGH_CYC = DEF_HIGH_CYC,
  parameter int LOW_CYC  = DEF_LOW_CYC
) (
  input  logic              CLK,
  input  logic              RST,
  updown_pulse_tx_if.slave  bus
);

  localparam int CNT_W = $clog2(max_int(HIGH_CYC, LOW_CYC) + 1);

  state_e               state_reg, state_next;
  sel_e                 sel_reg, sel_next;
  logic [WIDTH-1:0]     tgt_reg, tgt_next;
  logic [WIDTH-1:0]     pos_reg, pos_next;
  logic                 pend_reg, pend_next;
  logic                 accept_reg, accept_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic [NUM_PULSE-1:0] pulse_reg, pulse_next;

  logic [WIDTH-1:0]     diff;
  logic                 decide;
  logic                 timer_start;
  logic [CNT_W-1:0]     timer_load;
  logic                 timer_expire;

  // Distance still to travel; its MSB picks the shorter direction.
  assign diff = tgt_reg - pos_reg;

  updown_pulse_tx_phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .CLK      (CLK),
    .RST      (RST),
    .start    (timer_start),
    .load_val (timer_load),
    .expire   (timer_expire)
  );

  // Next-state, step decision and host-strobe handling.
  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    tgt_next    = tgt_reg;
    pos_next    = pos_reg;
    pend_next   = pend_reg;
    done_next   = 1'b0;
    decide      = 1'b0;
    timer_start = 1'b0;
    timer_load  = CNT_W'(HIGH_CYC);

    case (state_reg)
      ST_IDLE: begin
        decide = 1'b1;
      end
      ST_HIGH: begin
        if (timer_expire) begin
          state_next  = ST_LOW;
          timer_start = 1'b1;
          timer_load  = CNT_W'(LOW_CYC);
        end
      end
      ST_LOW: begin
        decide = timer_expire;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (decide) begin
      if (pend_reg) begin
        // Clear pre-empts stepping; the mirror and target restart at 0.
        state_next  = ST_HIGH;
        sel_next    = SEL_CLR;
        pos_next    = '0;
        tgt_next    = '0;
        pend_next   = 1'b0;
        timer_start = 1'b1;
      end else if (diff == '0) begin
        // Report arrival only after real work or a fresh request, so an
        // idle block does not pulse DONE every cycle.
        state_next = ST_IDLE;
        done_next  = (state_reg == ST_LOW) || accept_reg;
      end else if (!diff[WIDTH-1]) begin
        state_next  = ST_HIGH;
        sel_next    = SEL_UP;
        pos_next    = pos_reg + WIDTH'(1);
        timer_start = 1'b1;
      end else begin
        // Half-way distance (MSB only) also steps down.
        state_next  = ST_HIGH;
        sel_next    = SEL_DN;
        pos_next    = pos_reg - WIDTH'(1);
        timer_start = 1'b1;
      end
    end

    // Host strobes are applied after the decision so a LOAD landing on
    // the same edge as a clear decision still keeps the new target, and
    // a CLR_REQ landing on that edge is kept pending for the next one.
    if (bus.CLR_REQ) begin
      pend_next = 1'b1;
    end else if (bus.LOAD) begin
      tgt_next = bus.TARGET;
    end
  end

  assign accept_next = bus.CLR_REQ || bus.LOAD;
  assign busy_next   = (state_next != ST_IDLE);

  // One-hot pulse lines derived from the upcoming state and select.
  for (genvar gi = 0; gi < NUM_PULSE; gi++) begin : g_pulse
    assign pulse_next[gi] = (state_next == ST_HIGH) && (2'(sel_next) == 2'(gi));
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= ST_IDLE;
      sel_reg    <= SEL_UP;
      tgt_reg    <= '0;
      pos_reg    <= '0;
      pend_reg   <= 1'b0;
      accept_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      pulse_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      tgt_reg    <= tgt_next;
      pos_reg    <= pos_next;
      pend_reg   <= pend_next;
      accept_reg <= accept_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      pulse_reg  <= pulse_next;
    end
  end

  assign bus.UP_OUT  = pulse_reg[SEL_UP];
  assign bus.DN_OUT  = pulse_reg[SEL_DN];
  assign bus.CLR_OUT = pulse_reg[SEL_CLR];
  assign bus.POS     = pos_reg;
  assign bus.BUSY    = busy_reg;
  assign bus.DONE    = done_reg;

endmodule

// File: tb/tb_updown_pulse_tx.sv
// Testbench for updown_pulse_tx: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// time-based behavioural model and a loopback copy of the receiver.
module tb_updown_pulse_tx;

  localparam int W  = 8;
  localparam int HC = 2;
  localparam int LC = 2;
  localparam int P  = HC + LC;

  logic CLK;
  logic RST;

  updown_pulse_tx_if #(.WIDTH(W)) bus ();

  updown_pulse_tx #(
    .WIDTH    (W),
    .HIGH_CYC (HC),
    .LOW_CYC  (LC)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (time based) ----------------
  int  cyc = 0;
  int  m_pos, m_tgt, m_t0, m_kind, m_d;
  bit  m_pend, m_acc, m_active, m_valid, m_was_step;
  bit  e_up, e_dn, e_clr, e_busy, e_done;
  int  e_pos;

  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      m_pos = 0; m_tgt = 0; m_pend = 0; m_acc = 0; m_active = 0;
      e_up = 0; e_dn = 0; e_clr = 0; e_busy = 0; e_done = 0; e_pos = 0;
      m_valid = 1;
    end else begin
      e_done = 0;
      // A decision happens whenever no pulse is running, or exactly one
      // full step period after the current pulse rose.
      if (!m_active || (cyc == m_t0 + P)) begin
        m_was_step = m_active;
        m_active   = 0;
        if (m_pend) begin
          m_kind = 2; m_active = 1; m_t0 = cyc;
          m_pos = 0; m_tgt = 0; m_pend = 0;
        end else begin
          m_d = (m_tgt - m_pos + 256) % 256;
          if (m_d == 0) begin
            e_done = m_was_step || m_acc;
          end else if (m_d < 128) begin
            m_kind = 0; m_active = 1; m_t0 = cyc; m_pos = (m_pos + 1) % 256;
          end else begin
            m_kind = 1; m_active = 1; m_t0 = cyc; m_pos = (m_pos + 255) % 256;
          end
        end
      end
      if (bus.CLR_REQ) m_pend = 1;
      else if (bus.LOAD) m_tgt = int'(bus.TARGET);
      m_acc  = bus.LOAD || bus.CLR_REQ;
      e_up   = m_active && (cyc - m_t0 < HC) && (m_kind == 0);
      e_dn   = m_active && (cyc - m_t0 < HC) && (m_kind == 1);
      e_clr  = m_active && (cyc - m_t0 < HC) && (m_kind == 2);
      e_busy = m_active;
      e_pos  = m_pos;
    end
  end

  // ---------------- loopback receiver ----------------
  logic [2:0] rx_s1, rx_s2, rx_s3;
  int         rx_cnt = 0;
  bit         rx_valid = 0;

  always @(posedge CLK) begin
    rx_s1 <= {bus.CLR_OUT, bus.DN_OUT, bus.UP_OUT};
    rx_s2 <= rx_s1;
    rx_s3 <= rx_s2;
    if (rx_s2[2] && !rx_s3[2]) begin
      rx_cnt   <= 0;
      rx_valid <= 1'b1;
    end else if (RST) begin
      rx_valid <= 1'b0;
    end else if (rx_s2[0] && !rx_s3[0]) begin
      rx_cnt <= (rx_cnt + 1) % 256;
    end else if (rx_s2[1] && !rx_s3[1]) begin
      rx_cnt <= (rx_cnt + 255) % 256;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (m_valid) begin
      chk("model{up,dn,clr,busy,done,pos}",
          int'({bus.UP_OUT, bus.DN_OUT, bus.CLR_OUT, bus.BUSY, bus.DONE, bus.POS}),
          int'({e_up, e_dn, e_clr, e_busy, e_done, 8'(e_pos)}));
      if ((int'(bus.UP_OUT) + int'(bus.DN_OUT) + int'(bus.CLR_OUT)) > 1)
        chk("one_hot", int'({bus.UP_OUT, bus.DN_OUT, bus.CLR_OUT}), 0);
      if (rx_valid && !bus.BUSY && !RST)
        chk("loopback", rx_cnt, int'(bus.POS));
    end
  end

  // ---------------- stimulus helpers ----------------
  int r_up, r_dn, r_clr, r_done;
  bit p_up, p_dn, p_clr;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic count_edges();
    if (bus.UP_OUT && !p_up)   r_up++;
    if (bus.DN_OUT && !p_dn)   r_dn++;
    if (bus.CLR_OUT && !p_clr) r_clr++;
    if (bus.DONE)              r_done++;
    p_up = bus.UP_OUT; p_dn = bus.DN_OUT; p_clr = bus.CLR_OUT;
  endtask

  // Run until DONE has been seen and BUSY is low, counting pulse edges.
  task automatic run_until_idle(input int limit);
    bit fin;
    int n;
    r_up = 0; r_dn = 0; r_clr = 0; r_done = 0;
    p_up = bus.UP_OUT; p_dn = bus.DN_OUT; p_clr = bus.CLR_OUT;
    fin = 0; n = 0;
    while (!fin && n < limit) begin
      tick();
      n++;
      count_edges();
      if (!bus.BUSY && r_done > 0) fin = 1;
    end
    chk("reached_idle", int'(fin), 1);
    repeat (3) begin
      tick();
      count_edges();
    end
  endtask

  task automatic strobe(input bit ld, input bit clr, input int tgt);
    bus.TARGET  = 8'(tgt);
    bus.LOAD    = ld;
    bus.CLR_REQ = clr;
    tick();
    bus.LOAD    = 1'b0;
    bus.CLR_REQ = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    RST = 1'b1;
    bus.TARGET = '0; bus.LOAD = 1'b0; bus.CLR_REQ = 1'b0;
    repeat (3) tick();
    chk("reset_outputs",
        int'({bus.UP_OUT, bus.DN_OUT, bus.CLR_OUT, bus.BUSY, bus.DONE, bus.POS}), 0);
    RST = 1'b0;
    tick();

    // Clear first so the loopback receiver has a known count.
    strobe(1'b0, 1'b1, 0);
    run_until_idle(40);
    chk("init_clear_pulses", r_clr, 1);

    // LOAD 3: UP high after E1,E2,E5,E6,E9,E10; DONE only after E13.
    strobe(1'b1, 1'b0, 3);
    for (int k = 1; k <= 13; k++) begin
      tick();
      chk($sformatf("s1_up_E%0d", k), int'(bus.UP_OUT), int'(k <= 10 && ((k - 1) % 4) < 2));
      chk($sformatf("s1_done_E%0d", k), int'(bus.DONE), int'(k == 13));
      chk($sformatf("s1_busy_E%0d", k), int'(bus.BUSY), int'(k < 13));
    end
    chk("s1_pos", int'(bus.POS), 3);

    // 3 -> 1: two DN pulses, one DONE.
    strobe(1'b1, 1'b0, 1);
    run_until_idle(40);
    chk("s2_dn", r_dn, 2);
    chk("s2_up", r_up, 0);
    chk("s2_done", r_done, 1);
    chk("s2_pos", int'(bus.POS), 1);

    // 0 -> 200: D=200 has MSB set, so 56 DN pulses and no UP pulses.
    strobe(1'b0, 1'b1, 0);
    run_until_idle(40);
    strobe(1'b1, 1'b0, 200);
    run_until_idle(56 * P + 20);
    chk("s3_dn", r_dn, 56);
    chk("s3_up", r_up, 0);
    chk("s3_pos", int'(bus.POS), 200);

    // Reach POS=4, then LOAD 10 and CLR_REQ mid-HIGH of the first UP.
    strobe(1'b0, 1'b1, 0);
    run_until_idle(40);
    strobe(1'b1, 1'b0, 4);
    run_until_idle(4 * P + 20);
    chk("s4_pre_pos", int'(bus.POS), 4);
    strobe(1'b1, 1'b0, 10);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("s4_up_E%0d", k), int'(bus.UP_OUT), int'(k <= 2));
      chk($sformatf("s4_clr_E%0d", k), int'(bus.CLR_OUT), int'(k == 5 || k == 6));
      chk($sformatf("s4_pos_E%0d", k), int'(bus.POS), (k <= 4) ? 5 : 0);
      chk($sformatf("s4_done_E%0d", k), int'(bus.DONE), int'(k == 9));
      bus.CLR_REQ = (k == 1);
    end
    bus.CLR_REQ = 1'b0;

    // LOAD 5 then LOAD 2 after the first UP rises, from POS=0: 2 UPs total.
    strobe(1'b1, 1'b0, 5);
    tick();
    chk("s5_first_up", int'(bus.UP_OUT), 1);
    strobe(1'b1, 1'b0, 2);
    run_until_idle(40);
    chk("s5_up_total", r_up + 1, 2);
    chk("s5_dn", r_dn, 0);
    chk("s5_pos", int'(bus.POS), 2);

    // LOAD and CLR_REQ together: clear only.
    strobe(1'b1, 1'b1, 7);
    run_until_idle(40);
    chk("s5b_clr", r_clr, 1);
    chk("s5b_steps", r_up + r_dn, 0);
    chk("s5b_pos", int'(bus.POS), 0);

    // LOAD TARGET==POS while IDLE: DONE after E1, no pulse, BUSY low.
    strobe(1'b1, 1'b0, 0);
    tick();
    chk("s5c_done", int'(bus.DONE), 1);
    chk("s5c_quiet", int'({bus.UP_OUT, bus.DN_OUT, bus.CLR_OUT, bus.BUSY}), 0);
    tick();
    chk("s5c_done_once", int'(bus.DONE), 0);

    // Reset during HIGH.
    strobe(1'b1, 1'b0, 3);
    tick();
    chk("s6_up_before_rst", int'(bus.UP_OUT), 1);
    RST = 1'b1;
    tick();
    chk("s6_after_rst",
        int'({bus.UP_OUT, bus.DN_OUT, bus.CLR_OUT, bus.BUSY, bus.POS}), 0);
    RST = 1'b0;
    strobe(1'b0, 1'b1, 0);
    run_until_idle(40);
    strobe(1'b1, 1'b0, 2);
    run_until_idle(40);
    chk("s6_up", r_up, 2);
    chk("s6_pos", int'(bus.POS), 2);

    // Randomized traffic; the model and loopback check every cycle.
    for (int i = 0; i < 6000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      bus.LOAD    = (r < 25);
      bus.CLR_REQ = (r >= 25 && r < 33);
      RST         = (r == 999);
      if ($urandom_range(0, 1) == 0)
        bus.TARGET = 8'(int'(bus.POS) + int'($urandom_range(0, 12)) - 6);
      else
        bus.TARGET = 8'($urandom_range(0, 255));
      tick();
    end
    bus.LOAD = 1'b0; bus.CLR_REQ = 1'b0; RST = 1'b0;
    repeat (600) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
